// File: rtl/rca_rr_arb_pkg.sv
// rtl/rca_rr_arb_pkg.sv - constants and helpers shared by the adder arbiter
`include "rca_arb_defs.vh"

package rca_rr_arb_pkg;

  localparam int DATA_W = `RCA_ARB_DATA_W;
  localparam int CNT_W  = `RCA_ARB_CNT_W;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Increment that sticks at the maximum count instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rca32.sv
// rtl/rca32.sv - 32-bit ripple-carry adder
module rca32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  // Carry ripples bit by bit from ci up to co.
  always_comb begin
    logic c;
    s = '0;
    c = ci;
    for (int i = 0; i < 32; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/rca_arb_defs.vh
// rtl/rca_arb_defs.vh - shared widths and defaults for the adder arbiter
`ifndef RCA_ARB_DEFS_VH
`define RCA_ARB_DEFS_VH

`define RCA_ARB_DATA_W 32
`define RCA_ARB_NREQ   4
`define RCA_ARB_IDW    2
`define RCA_ARB_CNT_W  16

`endif

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - combinational one-hot round-robin select
module rr_grant #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt
);

  // Rotate so ptr sits at bit 0, keep the lowest request, rotate back.
  always_comb begin
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   pick;
    logic [2*NREQ-1:0] back;
    dbl  = {req, req} >> ptr;
    rot  = dbl[NREQ-1:0];
    pick = rot & (~rot + NREQ'(1));
    back = {pick, pick} << ptr;
    gnt  = en ? back[2*NREQ-1:NREQ] : '0;
  end

endmodule

// File: rtl/rca_rr_arb.sv
// rtl/rca_rr_arb.sv - round-robin arbiter sharing one rca32; stats with RCA_RR_ARB_STATS_EN
`include "rca_arb_defs.vh"

module rca_rr_arb
  import rca_rr_arb_pkg::*;
#(
  parameter int NREQ = `RCA_ARB_NREQ,
  parameter int IDW  = `RCA_ARB_IDW
) (
  input  logic                   clk,
  input  logic                   reset_n,
`ifdef RCA_RR_ARB_STATS_EN
  input  logic                   stats_clr,
  output logic [CNT_W*NREQ-1:0]  gnt_cnt,
`endif
  input  logic [NREQ-1:0]        req,
  input  logic [DATA_W*NREQ-1:0] a_in,
  input  logic [DATA_W*NREQ-1:0] b_in,
  input  logic [NREQ-1:0]        ci_in,
  output logic [NREQ-1:0]        gnt,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [DATA_W-1:0]      rsp_s,
  output logic                   rsp_co
);

  logic              stall;
  logic              accept;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    gnt_idx;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              sel_ci;

  logic              v1;
  logic [IDW-1:0]    id1;
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] b1;
  logic              ci1;
  logic [DATA_W-1:0] sum;
  logic              sum_co;

  assign stall  = rsp_valid & ~rsp_ready;
  assign accept = |(gnt & req);

  rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_rr_grant (
    .req (req),
    .ptr (ptr),
    .en  (reset_n & ~stall),
    .gnt (gnt)
  );

  // Encode the one-hot grant and mux out the granted requester's operands.
  always_comb begin
    gnt_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_ci  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = IDW'(i);
        sel_a   = a_in[DATA_W*i +: DATA_W];
        sel_b   = b_in[DATA_W*i +: DATA_W];
        sel_ci  = ci_in[i];
      end
    end
  end

  // Pointer moves just past the requester that was served.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
    end
  end

  // Stage 1: operand register; holds its entry while the output is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1  <= 1'b0;
      id1 <= '0;
      a1  <= '0;
      b1  <= '0;
      ci1 <= 1'b0;
    end else if (accept) begin
      v1  <= 1'b1;
      id1 <= gnt_idx;
      a1  <= sel_a;
      b1  <= sel_b;
      ci1 <= sel_ci;
    end else if (!stall) begin
      v1  <= 1'b0;
    end
  end

  rca32 u_rca32 (
    .a  (a1),
    .b  (b1),
    .ci (ci1),
    .s  (sum),
    .co (sum_co)
  );

  // Stage 2: result register; payload only updates when a new sum arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_s     <= '0;
      rsp_co    <= 1'b0;
    end else if (!stall) begin
      rsp_valid <= v1;
      if (v1) begin
        rsp_id <= id1;
        rsp_s  <= sum;
        rsp_co <= sum_co;
      end
    end
  end

`ifdef RCA_RR_ARB_STATS_EN
  // Per-requester saturating grant counters; a clear beats a same-cycle grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_cnt <= '0;
    end else if (stats_clr) begin
      gnt_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] & req[i]) begin
          gnt_cnt[CNT_W*i +: CNT_W] <= sat_inc(gnt_cnt[CNT_W*i +: CNT_W]);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rca_rr_arb.sv
// tb/tb_rca_rr_arb.sv - directed self-checking bench for rca_rr_arb
module tb_rca_rr_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [32*NREQ-1:0] a_in;
  logic [32*NREQ-1:0] b_in;
  logic [NREQ-1:0]   ci_in;
  logic [NREQ-1:0]   gnt;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_s;
  logic              rsp_co;
`ifdef RCA_RR_ARB_STATS_EN
  logic              stats_clr;
  logic [16*NREQ-1:0] gnt_cnt;
`endif

  logic [31:0] a_arr [NREQ];
  logic [31:0] b_arr [NREQ];

  int tests_run;
  int tests_failed;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign a_in[32*g +: 32] = a_arr[g];
    assign b_in[32*g +: 32] = b_arr[g];
  end

  rca_rr_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef RCA_RR_ARB_STATS_EN
    .stats_clr (stats_clr),
    .gnt_cnt   (gnt_cnt),
`endif
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .ci_in     (ci_in),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_s     (rsp_s),
    .rsp_co    (rsp_co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] exp_sum;
    int gi;
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    rsp_ready    = 1'b1;
    req          = 4'b1111;
    ci_in        = '0;
`ifdef RCA_RR_ARB_STATS_EN
    stats_clr    = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end

    // Reset state
    tick();
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_valid", 64'(rsp_valid), 64'h0);
    chk("rst_ptr", 64'(dut.ptr), 64'h0);
    req = '0;
    tick();
    reset_n = 1'b1;
    tick();

    // Single op with carry out
    a_arr[2] = 32'hFFFF_FFFF;
    b_arr[2] = 32'h0000_0001;
    ci_in    = 4'b0000;
    req      = 4'b0100;
    #1;
    chk("single_gnt", 64'(gnt), 64'h4);
    tick();
    req = '0;
    chk("single_ptr", 64'(dut.ptr), 64'h3);
    chk("single_v1_lat", 64'(rsp_valid), 64'h0);
    tick();
    chk("single_valid", 64'(rsp_valid), 64'h1);
    chk("single_id", 64'(rsp_id), 64'h2);
    chk("single_s", 64'(rsp_s), 64'h0);
    chk("single_co", 64'(rsp_co), 64'h1);
    tick();
    chk("single_drain", 64'(rsp_valid), 64'h0);

    // Wrap and skip: ptr=3, req=0101
    req = 4'b0101;
    #1;
    chk("wrap_gnt0", 64'(gnt), 64'h1);
    tick();
    chk("wrap_ptr1", 64'(dut.ptr), 64'h1);
    chk("wrap_gnt2", 64'(gnt), 64'h4);
    tick();
    req = '0;
    chk("wrap_ptr3", 64'(dut.ptr), 64'h3);
    tick();
    tick();

    // Bring ptr to 0, then all four request for 8 cycles
    req = 4'b1000;
    tick();
    req = '0;
    tick();
    tick();
    chk("rr_ptr_start", 64'(dut.ptr), 64'h0);
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = 32'h1111_1111 * (i + 1);
      b_arr[i] = 32'hE000_0000 + 32'(i);
    end
    ci_in = 4'b1010;
    for (int k = 0; k < 10; k++) begin
      req = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 8) chk($sformatf("rr_gnt%0d", k), 64'(gnt), 64'(1 << (k % 4)));
      tick();
      if (k >= 1 && k <= 8) begin
        gi = (k - 1) % 4;
        exp_sum = {1'b0, a_arr[gi]} + {1'b0, b_arr[gi]} + 33'(ci_in[gi]);
        chk($sformatf("rr_valid%0d", k), 64'(rsp_valid), 64'h1);
        chk($sformatf("rr_id%0d", k), 64'(rsp_id), 64'(gi));
        chk($sformatf("rr_sum%0d", k), 64'({rsp_co, rsp_s}), 64'(exp_sum));
      end
    end
    chk("rr_drain", 64'(rsp_valid), 64'h0);

    // Backpressure: 1+1+1 from requesters 0 and 1
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = 32'h1;
      b_arr[i] = 32'h1;
    end
    ci_in = 4'b1111;
    req   = 4'b0011;
    #1;
    chk("bp_gnt0", 64'(gnt), 64'h1);
    tick();
    chk("bp_gnt1", 64'(gnt), 64'h2);
    tick();
    rsp_ready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_stall_gnt%0d", c), 64'(gnt), 64'h0);
      chk($sformatf("bp_stall_valid%0d", c), 64'(rsp_valid), 64'h1);
      chk($sformatf("bp_stall_id%0d", c), 64'(rsp_id), 64'h0);
      chk($sformatf("bp_stall_s%0d", c), 64'(rsp_s), 64'h3);
      tick();
    end
    rsp_ready = 1'b1;
    req       = '0;
    tick();
    chk("bp_next_valid", 64'(rsp_valid), 64'h1);
    chk("bp_next_id", 64'(rsp_id), 64'h1);
    chk("bp_next_s", 64'(rsp_s), 64'h3);
    tick();
    chk("bp_no_dup", 64'(rsp_valid), 64'h0);

    // Reset mid-stream with two ops in flight
    req = 4'b0011;
    tick();
    tick();
    chk("mid_pre_s", 64'(rsp_s), 64'h3);
    reset_n = 1'b0;
    #1;
    chk("mid_valid", 64'(rsp_valid), 64'h0);
    chk("mid_s", 64'(rsp_s), 64'h0);
    chk("mid_ptr", 64'(dut.ptr), 64'h0);
    chk("mid_gnt", 64'(gnt), 64'h0);
    tick();
    reset_n = 1'b1;
    req     = 4'b1000;
    #1;
    chk("post_rst_gnt", 64'(gnt), 64'h8);
    tick();
    req = '0;
    tick();
    tick();
    chk("post_rst_valid", 64'(rsp_valid), 64'h0);

`ifdef RCA_RR_ARB_STATS_EN
    // Five grants to requester 1, then a clear alongside a sixth
    chk("st_cnt3", 64'(gnt_cnt[48 +: 16]), 64'h1);
    req = 4'b0010;
    for (int c = 0; c < 5; c++) tick();
    chk("st_cnt1_five", 64'(gnt_cnt[16 +: 16]), 64'h5);
    chk("st_gnt_clr", 64'(gnt), 64'h2);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    req       = '0;
    chk("st_cnt1_clr", 64'(gnt_cnt[16 +: 16]), 64'h0);
    chk("st_cnt3_clr", 64'(gnt_cnt[48 +: 16]), 64'h0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
